// File: rtl/fifo_word_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// fifo_word_unpacker_pkg
// Shared definitions for the FIFO word unpacker: the FSM state encoding,
// default geometry and helpers that derive the beat count and the width
// of the beat index from the word/beat widths.
// -----------------------------------------------------------------------------
package fifo_word_unpacker_pkg;

  // IDLE: waiting for work, REQ: pop strobe, LOAD: capture word, SEND: beats
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    LOAD = 2'b10,
    SEND = 2'b11
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

  // Number of beats carried by one FIFO word
  function automatic int calc_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Width of the beat index; at least one bit so the index always exists
  function automatic int calc_idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// -----------------------------------------------------------------------------
// fifo_word_unpacker_if
// Bundles the FIFO read side and the byte stream side of the unpacker.
//   master : the unpacker (drives fifo_cs/fifo_rd_en, out_*, busy, word_count)
//   slave  : the environment (drives enable, fifo_empty, fifo_rdata, out_ready)
// -----------------------------------------------------------------------------
interface fifo_word_unpacker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [BYTE_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  word_count;

  modport master (
    input  enable, fifo_empty, fifo_rdata, out_ready,
    output fifo_cs, fifo_rd_en, out_valid, out_data, out_last, busy, word_count
  );

  modport slave (
    output enable, fifo_empty, fifo_rdata, out_ready,
    input  fifo_cs, fifo_rd_en, out_valid, out_data, out_last, busy, word_count
  );
endinterface

// File: rtl/fifo_word_unpacker_byte_selector.sv
// -----------------------------------------------------------------------------
// fifo_word_unpacker_byte_selector
// Registered N:1 beat mux. Holds the popped word and presents one beat at a
// time; the presented beat only changes on load or advance, so it is stable
// while the consumer stalls.
//   i_load    : capture i_word and present its first beat
//   i_advance : present beat i_idx of the held word
//   i_done    : final beat accepted, drop the last flag
//   o_data    : current beat, o_last : current beat is the final one
// -----------------------------------------------------------------------------
module fifo_word_unpacker_byte_selector
  import fifo_word_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int LSB_FIRST  = 1,
  parameter int IDX_W      = calc_idx_width(calc_bytes(DATA_WIDTH, BYTE_WIDTH))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic                  i_done,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [IDX_W-1:0]      i_idx,
  output logic [BYTE_WIDTH-1:0] o_data,
  output logic                  o_last
);

  localparam int N = calc_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic [DATA_WIDTH-1:0] r_word;
  logic [BYTE_WIDTH-1:0] r_data;
  logic                  r_last;

  // Beat idx in emission order; MSB-first mode counts from the top byte down
  function automatic logic [BYTE_WIDTH-1:0] pick(input logic [DATA_WIDTH-1:0] word,
                                                 input logic [IDX_W-1:0]      idx);
    int                    pos;
    logic [DATA_WIDTH-1:0] shifted;
    if (LSB_FIRST != 0) begin
      pos = int'(idx);
    end else begin
      pos = N - 1 - int'(idx);
    end
    shifted = word >> (pos * BYTE_WIDTH);
    return shifted[BYTE_WIDTH-1:0];
  endfunction

  // Word capture and beat presentation; holds when no event occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_word <= i_word;
      r_data <= pick(i_word, IDX_W'(0));
      r_last <= 1'b0;
    end else if (i_advance) begin
      r_data <= pick(r_word, i_idx);
      r_last <= (i_idx == IDX_W'(N - 1));
    end else if (i_done) begin
      r_last <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_last = r_last;

endmodule

// File: rtl/fifo_word_unpacker.sv
// -----------------------------------------------------------------------------
// fifo_word_unpacker
// Drains a synchronous FIFO one word at a time and emits each word as
// DATA_WIDTH/BYTE_WIDTH beats on a valid/ready stream.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : master modport of fifo_word_unpacker_if
//                (enable, fifo_empty, fifo_rdata, out_ready in;
//                 fifo_cs, fifo_rd_en, out_valid, out_data, out_last,
//                 busy, word_count out)
// Every output is a flop. A pop (REQ) is followed by one LOAD cycle because
// the FIFO presents data the cycle after the read strobe.
// -----------------------------------------------------------------------------
module fifo_word_unpacker
  import fifo_word_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int LSB_FIRST  = 1,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_word_unpacker_if.master  bus
);

  localparam int N     = calc_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int IDX_W = calc_idx_width(N);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rd_en;
  logic                  r_valid;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_last_xfer;
  logic [BYTE_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

  assign w_start     = bus.enable && !bus.fifo_empty;
  // out_valid is high exactly in SEND, so the state stands in for it here
  assign w_xfer      = (r_state == SEND) && bus.out_ready;
  assign w_last_xfer = w_xfer && (r_idx == IDX_W'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ:  w_state_nxt = LOAD;
      LOAD: w_state_nxt = SEND;
      SEND: begin
        if (w_last_xfer) begin
          if (w_start) begin
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status flops track the state being entered so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rd_en <= (w_state_nxt == REQ);
      r_valid <= (w_state_nxt == SEND);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Beat index: cleared while loading, stepped on each non-final transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (r_state == LOAD) begin
      r_idx <= '0;
    end else if (w_xfer && !w_last_xfer) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Completed-word counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_last_xfer) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  fifo_word_unpacker_byte_selector #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .LSB_FIRST  (LSB_FIRST),
    .IDX_W      (IDX_W)
  ) u_byte_selector (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (r_state == LOAD),
    .i_advance (w_xfer && !w_last_xfer),
    .i_done    (w_last_xfer),
    .i_word    (bus.fifo_rdata),
    .i_idx     (r_idx + IDX_W'(1)),
    .o_data    (w_sel_data),
    .o_last    (w_sel_last)
  );

  assign bus.fifo_cs    = r_rd_en;
  assign bus.fifo_rd_en = r_rd_en;
  assign bus.out_valid  = r_valid;
  assign bus.out_data   = w_sel_data;
  assign bus.out_last   = w_sel_last;
  assign bus.busy       = r_busy;
  assign bus.word_count = r_count;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_unpacker
// Two unpackers (LSB-first and MSB-first) run in lockstep on the same inputs.
// A queue stands in for the FIFO; popped words are expanded into expected
// beats by plain byte arithmetic and compared with the accepted beats.
// -----------------------------------------------------------------------------
module tb_fifo_word_unpacker;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          empty = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] rdata = '0;

  always #5 clk = ~clk;

  fifo_word_unpacker_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .CNT_WIDTH(CW)) if_l ();
  fifo_word_unpacker_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .CNT_WIDTH(CW)) if_m ();

  assign if_l.enable = en;  assign if_l.fifo_empty = empty;
  assign if_l.fifo_rdata = rdata;  assign if_l.out_ready = ready;
  assign if_m.enable = en;  assign if_m.fifo_empty = empty;
  assign if_m.fifo_rdata = rdata;  assign if_m.out_ready = ready;

  fifo_word_unpacker #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .LSB_FIRST(1), .CNT_WIDTH(CW))
    u_dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
  fifo_word_unpacker #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .LSB_FIRST(0), .CNT_WIDTH(CW))
    u_dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] popped[$];
  logic [8:0]    obs_l[$];
  logic [8:0]    obs_m[$];
  int            rd_cyc[$];
  int n_rd = 0, n_rd_empty = 0, n_lock = 0, n_hold = 0, cyc = 0;

  // Expected beat j of the popped words: {last, byte}
  function automatic logic [8:0] model_beat(input int j, input bit lsb);
    int w, i, b;
    logic [DW-1:0] word;
    w = j / NB;
    i = j % NB;
    b = lsb ? i : (NB - 1 - i);
    if (w >= popped.size()) return 9'h1ff;
    word = popped[w];
    return {(i == NB - 1), word[b*BW +: BW]};
  endfunction

  // One clock: record handshakes and reads, then emulate the FIFO data port
  task automatic tick();
    logic rd_pre, stall_pre;
    logic [8:0] held_l, held_m;
    rd_pre    = if_l.fifo_rd_en;
    stall_pre = if_l.out_valid && !ready;
    held_l    = {if_l.out_last, if_l.out_data};
    held_m    = {if_m.out_last, if_m.out_data};
    if (if_l.out_valid && ready) begin
      obs_l.push_back(held_l);
      obs_m.push_back(held_m);
    end
    if (rd_pre) begin
      n_rd++;
      rd_cyc.push_back(cyc);
      if (empty) n_rd_empty++;
    end
    if ((if_l.fifo_rd_en !== if_m.fifo_rd_en) || (if_l.out_valid !== if_m.out_valid) ||
        (if_l.busy !== if_m.busy) || (if_l.word_count !== if_m.word_count) ||
        (if_l.fifo_cs !== if_l.fifo_rd_en) || (if_l.out_valid && !if_l.busy))
      n_lock++;
    @(posedge clk);
    #1;
    if (rd_pre && fq.size() > 0) begin
      rdata = fq.pop_front();
      popped.push_back(rdata);
    end
    empty = (fq.size() == 0);
    if (stall_pre && ((if_l.out_valid !== 1'b1) || ({if_l.out_last, if_l.out_data} !== held_l) ||
                      ({if_m.out_last, if_m.out_data} !== held_m)))
      n_hold++;
    cyc++;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    empty = 1'b0;
  endtask

  task automatic clear_logs();
    obs_l.delete(); obs_m.delete(); popped.delete(); rd_cyc.delete();
    n_rd = 0;
  endtask

  // Run until idle with nothing to start, bounded by budget
  task automatic drain(input int budget, output bit timed_out);
    int k;
    k = 0;
    while ((if_l.busy || (en && !empty)) && k < budget) begin
      tick();
      k++;
    end
    timed_out = (k >= budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ready = 1'b0;
    #12;
    n_checks++; if ({if_l.fifo_rd_en, if_l.fifo_cs, if_l.out_valid, if_l.out_last, if_l.busy} !== 5'b0) begin
      n_errors++; $display("FAIL reset_ctrl_l: got %b expected 00000", {if_l.fifo_rd_en, if_l.fifo_cs, if_l.out_valid, if_l.out_last, if_l.busy}); end
    n_checks++; if ({if_m.fifo_rd_en, if_m.fifo_cs, if_m.out_valid, if_m.out_last, if_m.busy} !== 5'b0) begin
      n_errors++; $display("FAIL reset_ctrl_m: got %b expected 00000", {if_m.fifo_rd_en, if_m.fifo_cs, if_m.out_valid, if_m.out_last, if_m.busy}); end
    n_checks++; if (if_l.out_data !== 8'h00 || if_m.out_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_data: got %h/%h expected 00", if_l.out_data, if_m.out_data); end
    n_checks++; if (if_l.word_count !== 16'd0 || if_m.word_count !== 16'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d/%0d expected 0", if_l.word_count, if_m.word_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    n_checks++; if (if_l.busy !== 1'b0 || if_l.fifo_rd_en !== 1'b0) begin
      n_errors++; $display("FAIL reset_release_idle: busy %b rd_en %b expected 0 0", if_l.busy, if_l.fifo_rd_en); end
  endtask

  task automatic test_single();
    logic [8:0] k_l[4];
    logic [8:0] k_m[4];
    k_l = '{9'h044, 9'h033, 9'h022, 9'h111};
    k_m = '{9'h011, 9'h022, 9'h033, 9'h144};
    clear_logs();
    ready = 1'b1;
    push(32'h11223344);
    en = 1'b1;
    tick();
    n_checks++; if (if_l.fifo_rd_en !== 1'b1 || if_l.fifo_cs !== 1'b1 || if_l.busy !== 1'b1) begin
      n_errors++; $display("FAIL single_req: rd_en %b cs %b busy %b expected 1 1 1", if_l.fifo_rd_en, if_l.fifo_cs, if_l.busy); end
    tick();
    n_checks++; if (if_l.fifo_rd_en !== 1'b0 || if_l.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_load: rd_en %b valid %b expected 0 0", if_l.fifo_rd_en, if_l.out_valid); end
    tick();
    n_checks++; if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'h44 || if_m.out_data !== 8'h11 || if_l.out_last !== 1'b0) begin
      n_errors++; $display("FAIL single_first_beat: valid %b data %h/%h last %b expected 1 44/11 0", if_l.out_valid, if_l.out_data, if_m.out_data, if_l.out_last); end
    repeat (3) tick();
    n_checks++; if (if_l.out_valid !== 1'b1 || if_l.out_last !== 1'b1 || if_l.out_data !== 8'h11 || if_m.out_data !== 8'h44) begin
      n_errors++; $display("FAIL single_last_beat: valid %b last %b data %h/%h expected 1 1 11/44", if_l.out_valid, if_l.out_last, if_l.out_data, if_m.out_data); end
    tick();
    n_checks++; if (if_l.busy !== 1'b0 || if_l.out_valid !== 1'b0 || if_l.word_count !== 16'd1 || if_l.out_last !== 1'b0) begin
      n_errors++; $display("FAIL single_done: busy %b valid %b count %0d last %b expected 0 0 1 0", if_l.busy, if_l.out_valid, if_l.word_count, if_l.out_last); end
    n_checks++; if (obs_l.size() != 4) begin
      n_errors++; $display("FAIL single_beats: got %0d beats expected 4", obs_l.size()); end
    for (int j = 0; j < obs_l.size() && j < 4; j++) begin
      n_checks++; if (obs_l[j] !== k_l[j] || obs_m[j] !== k_m[j]) begin
        n_errors++; $display("FAIL single_beat%0d: got %h/%h expected %h/%h", j, obs_l[j], obs_m[j], k_l[j], k_m[j]); end
    end
    repeat (5) tick();
    n_checks++; if (n_rd != 1) begin
      n_errors++; $display("FAIL single_rd_count: got %0d expected 1", n_rd); end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    clear_logs();
    ready = 1'b1;
    push(32'hA1B2C3D4);
    en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    n_checks++; if (if_l.out_data !== 8'hD4 || if_m.out_data !== 8'hA1) begin
      n_errors++; $display("FAIL bp_first: got %h/%h expected d4/a1", if_l.out_data, if_m.out_data); end
    tick();
    ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'hC3 || if_m.out_data !== 8'hB2) begin
        n_errors++; $display("FAIL bp_stall%0d: valid %b data %h/%h expected 1 c3/b2", s, if_l.out_valid, if_l.out_data, if_m.out_data); end
      tick();
    end
    ready = 1'b1;
    n_checks++; if (if_l.out_valid !== 1'b1 || if_l.out_data !== 8'hC3) begin
      n_errors++; $display("FAIL bp_resume: valid %b data %h expected 1 c3", if_l.out_valid, if_l.out_data); end
    repeat (3) tick();
    n_checks++; if (obs_l.size() != 4 || if_l.busy !== 1'b0 || if_l.word_count !== 16'd2) begin
      n_errors++; $display("FAIL bp_done: beats %0d busy %b count %0d expected 4 0 2", obs_l.size(), if_l.busy, if_l.word_count); end
    for (int j = 0; j < obs_l.size(); j++) begin
      n_checks++; if (obs_l[j] !== model_beat(j, 1'b1) || obs_m[j] !== model_beat(j, 1'b0)) begin
        n_errors++; $display("FAIL bp_beat%0d: got %h/%h expected %h/%h", j, obs_l[j], obs_m[j], model_beat(j, 1'b1), model_beat(j, 1'b0)); end
    end
    n_checks++; if (n_hold != 0) begin
      n_errors++; $display("FAIL bp_hold: got %0d unstable stall cycles expected 0", n_hold); end
  endtask

  task automatic test_back_to_back();
    bit to;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_logs();
    push(32'd1); push(32'd10); push(32'd100);
    ready = 1'b1;
    en = 1'b1;
    drain(200, to);
    n_checks++; if (to) begin
      n_errors++; $display("FAIL b2b_timeout: got busy after 200 cycles expected idle"); end
    n_checks++; if (n_rd != 3) begin
      n_errors++; $display("FAIL b2b_rd_count: got %0d expected 3", n_rd); end
    for (int k = 1; k < rd_cyc.size(); k++) begin
      n_checks++; if (rd_cyc[k] - rd_cyc[k-1] != NB + 2) begin
        n_errors++; $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d", k, rd_cyc[k] - rd_cyc[k-1], NB + 2); end
    end
    n_checks++; if (obs_l.size() != 12 || if_l.word_count !== 16'd3) begin
      n_errors++; $display("FAIL b2b_totals: beats %0d count %0d expected 12 3", obs_l.size(), if_l.word_count); end
    for (int j = 0; j < obs_l.size(); j++) begin
      n_checks++; if (obs_l[j] !== model_beat(j, 1'b1) || obs_m[j] !== model_beat(j, 1'b0)) begin
        n_errors++; $display("FAIL b2b_beat%0d: got %h/%h expected %h/%h", j, obs_l[j], obs_m[j], model_beat(j, 1'b1), model_beat(j, 1'b0)); end
    end
    repeat (10) tick();
    n_checks++; if (n_rd != 3 || if_l.busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_quiet: rd %0d busy %b expected 3 0", n_rd, if_l.busy); end
  endtask

  task automatic test_empty_disabled();
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++; if (if_l.fifo_rd_en !== 1'b0 || if_l.busy !== 1'b0) begin
        n_errors++; $display("FAIL empty_idle%0d: rd_en %b busy %b expected 0 0", c, if_l.fifo_rd_en, if_l.busy); end
    end
  endtask

  task automatic test_enable_drop();
    bit to;
    clear_logs();
    push(32'hCAFE0001); push(32'hBEEF0002);
    ready = 1'b1;
    en = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    drain(50, to);
    repeat (5) tick();
    n_checks++; if (to || n_rd != 1 || fq.size() != 1) begin
      n_errors++; $display("FAIL endrop_reads: timeout %0d rd %0d left %0d expected 0 1 1", to, n_rd, fq.size()); end
    n_checks++; if (obs_l.size() != NB) begin
      n_errors++; $display("FAIL endrop_beats: got %0d expected %0d", obs_l.size(), NB); end
    for (int j = 0; j < obs_l.size(); j++) begin
      n_checks++; if (obs_l[j] !== model_beat(j, 1'b1) || obs_m[j] !== model_beat(j, 1'b0)) begin
        n_errors++; $display("FAIL endrop_beat%0d: got %h/%h expected %h/%h", j, obs_l[j], obs_m[j], model_beat(j, 1'b1), model_beat(j, 1'b0)); end
    end
    fq.delete();
    empty = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_logs();
    push(32'h01020304); push(32'h55667788);
    ready = 1'b1;
    en = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if_l.out_valid !== 1'b0 || if_l.fifo_rd_en !== 1'b0 || if_l.word_count !== 16'd0 || if_l.busy !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_async: valid %b rd_en %b count %0d busy %b expected 0 0 0 0", if_l.out_valid, if_l.fifo_rd_en, if_l.word_count, if_l.busy); end
    n_checks++; if (if_l.out_data !== 8'h00 || if_m.out_valid !== 1'b0 || if_m.out_data !== 8'h00) begin
      n_errors++; $display("FAIL rstmid_data: data %h/%h valid_m %b expected 00/00 0", if_l.out_data, if_m.out_data, if_m.out_valid); end
    tick();
    rst_n = 1'b1;
    clear_logs();
    drain(50, to);
    n_checks++; if (to || popped.size() != 1 || obs_l.size() != NB || if_l.word_count !== 16'd1) begin
      n_errors++; $display("FAIL rstmid_next: timeout %0d pops %0d beats %0d count %0d expected 0 1 %0d 1", to, popped.size(), obs_l.size(), if_l.word_count, NB); end
    n_checks++; if (obs_l.size() > 0 && (obs_l[0] !== 9'h088 || obs_m[0] !== 9'h055)) begin
      n_errors++; $display("FAIL rstmid_first: got %h/%h expected 088/055", obs_l[0], obs_m[0]); end
    for (int j = 0; j < obs_l.size(); j++) begin
      n_checks++; if (obs_l[j] !== model_beat(j, 1'b1) || obs_m[j] !== model_beat(j, 1'b0)) begin
        n_errors++; $display("FAIL rstmid_beat%0d: got %h/%h expected %h/%h", j, obs_l[j], obs_m[j], model_beat(j, 1'b1), model_beat(j, 1'b0)); end
    end
  endtask

  task automatic test_random();
    int nw, k;
    logic [CW-1:0] wc0;
    clear_logs();
    wc0 = if_l.word_count;
    nw = $urandom_range(6, 12);
    for (int i = 0; i < nw; i++) push($urandom);
    k = 0;
    while ((if_l.busy || !empty) && k < 3000) begin
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 4) != 0);
      tick();
      k++;
    end
    ready = 1'b1;
    n_checks++; if (k >= 3000 || popped.size() != nw) begin
      n_errors++; $display("FAIL rand_progress: cycles %0d pops %0d expected <3000 %0d", k, popped.size(), nw); end
    n_checks++; if (obs_l.size() != nw * NB || if_l.word_count !== CW'(wc0 + CW'(nw))) begin
      n_errors++; $display("FAIL rand_totals: beats %0d count %0d expected %0d %0d", obs_l.size(), if_l.word_count, nw * NB, CW'(wc0 + CW'(nw))); end
    for (int j = 0; j < obs_l.size(); j++) begin
      n_checks++; if (obs_l[j] !== model_beat(j, 1'b1) || obs_m[j] !== model_beat(j, 1'b0)) begin
        n_errors++; $display("FAIL rand_beat%0d: got %h/%h expected %h/%h", j, obs_l[j], obs_m[j], model_beat(j, 1'b1), model_beat(j, 1'b0)); end
    end
    n_checks++; if (n_hold != 0 || n_rd_empty != 0 || n_lock != 0) begin
      n_errors++; $display("FAIL rand_invariants: hold %0d rd_empty %0d lockstep %0d expected 0 0 0", n_hold, n_rd_empty, n_lock); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_empty_disabled();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fifo_word_unpacker.md
Name: fifo_word_unpacker

Overview:
Downstream drain stage for the team's synchronous FIFO (fifo). It pops one DATA_WIDTH word at a time through the FIFO's cs/rd_en/data_out/empty interface. Each word is emitted as a stream of BYTE_WIDTH beats on a valid/ready output. It feeds byte-oriented consumers such as a serial TX or a checksum unit.

Parameters:
DATA_WIDTH, 32, width of FIFO words; must be an integer multiple of BYTE_WIDTH with ratio >= 2
BYTE_WIDTH, 8, width of each output beat
LSB_FIRST, 1, 1 = least-significant byte emitted first, 0 = most-significant first
CNT_WIDTH, 16, width of word_count

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  drain enable; sampled only when deciding to start a new word
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  DATA_WIDTH  FIFO data_out
fifo_cs  output  1  FIFO chip select; equal to fifo_rd_en
fifo_rd_en  output  1  FIFO read strobe, one-cycle pulse per word
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  BYTE_WIDTH  output beat
out_last  output  1  high with the final beat of each word
busy  output  1  high in any state other than IDLE
word_count  output  CNT_WIDTH  words fully emitted since reset; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. fifo_rd_en, fifo_cs, out_valid, out_last and busy all 0. out_data=0, word_count=0, beat index=0. Shift register cleared.
- FIFO contract: fifo_rdata is valid in the cycle after the cycle in which fifo_rd_en is high. A read with fifo_empty high is never issued.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, REQ, LOAD, SEND.
- IDLE: when enable=1 and fifo_empty=0 at a clock edge, go to REQ. Otherwise stay.
- REQ: fifo_rd_en=fifo_cs=1 for exactly this one cycle. Next state is LOAD unconditionally.
- LOAD: strobes low. fifo_rdata is captured into the shift register at the end of this cycle. Beat index=0. Next state is SEND.
- SEND: out_valid=1. out_data = byte[index] when LOAD... more precisely: byte[index] if LSB_FIRST=1, else byte[N-1-index], where N=DATA_WIDTH/BYTE_WIDTH. out_last=1 when index=N-1.
- A beat transfers on a clock edge where out_valid and out_ready are both high; index then increments.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Final beat transfer: word_count increments. If enable=1 and fifo_empty=0 at that edge, go directly to REQ; otherwise go to IDLE.
- Latency: the start condition sampled at edge k gives fifo_rd_en in cycle k+1 and out_valid from cycle k+3. With out_ready held high, steady-state throughput is N beats per N+2 cycles.
- enable deasserted mid-word: the current word completes fully; then the block goes to IDLE.
- fifo_empty rising mid-word: no effect on the word in flight.
- Reset mid-operation: the word in flight is discarded (it has already been popped from the FIFO). Outputs take reset values immediately.
- out_valid is never asserted outside SEND. fifo_rd_en is never asserted outside REQ.

Decomposition:
- Shared package fifo_pkg holds:
  - state enum (IDLE, REQ, LOAD, SEND, 2-bit encoding)
  - localparam BYTES_PER_WORD = DATA_WIDTH/BYTE_WIDTH
  - index width = clog2(BYTES_PER_WORD)
- Natural sub-module: byte_selector. It is a registered N:1 beat mux with hold-on-stall, parameterised by LSB_FIRST. FSM and counters stay in the top.

Test Plan:
- Reset, FIFO loaded with 0x11223344, enable=1, out_ready=1 -> single rd_en pulse; beats 0x44,0x33,0x22,0x11 on consecutive cycles; out_last only on 0x11; word_count=1; returns to IDLE.
- LSB_FIRST=0, same word -> beats 0x11,0x22,0x33,0x44, out_last on 0x44.
- Backpressure: out_ready low for 3 cycles during the second beat of 0xA1B2C3D4 (LSB_FIRST=1) -> 0xC3 held stable with out_valid=1 for all 3 stall cycles; all four beats delivered once each, in order.
- Back-to-back: FIFO holds 1, 10, 100 -> exactly 3 rd_en pulses, each 2 cycles after the previous word's last beat handshake; 12 beats total; word_count=3; then IDLE with fifo_empty=1 and no further rd_en.
- Empty/disabled: enable=1 with the FIFO empty for 20 cycles -> fifo_rd_en never high, busy=0. Separately, enable dropped during beat 1 -> word completes, no new read issued.
- Reset mid-word: rst_n pulsed low during beat 2 -> out_valid, fifo_rd_en and word_count go to 0 immediately. After release with enable=1 and FIFO non-empty, the next FIFO word is emitted from its first beat.
